// File: rtl/bubble_access_controller.sv
// bubble_access_controller: sequences one bubble-memory page access (seek, replicate, transfer, stop)
// and tracks the absolute major-loop position from the timing generator's step pulses.
module bubble_access_controller #(
    parameter int LOOP_POSITIONS = 2053,
    parameter int ADDR_W         = 12,
    parameter int DETECT_DELAY   = 6,
    parameter int DATA_BITS      = 512,
    parameter int CNT_W          = 10,
    parameter int REP_HOLD       = 8
) (
    input  logic              master_clock,
    input  logic              reset_n,
    input  logic              access_request,
    input  logic [ADDR_W-1:0] access_page,
    input  logic              bootloop_request,
    input  logic              access_abort,
    input  logic              position_change,
    input  logic              coil_run,
    output logic              bubble_shift_enable,
    output logic              replicator_enable,
    output logic              bootloop_enable,
    output logic              access_busy,
    output logic              access_done,
    output logic              bit_valid,
    output logic [CNT_W-1:0]  bit_index,
    output logic [ADDR_W-1:0] current_position
);
    localparam int HOLD_W = $clog2(REP_HOLD + 1);
    localparam logic [ADDR_W-1:0] POS_LAST  = ADDR_W'(LOOP_POSITIONS - 1);
    localparam logic [CNT_W-1:0]  FIRST_BIT = CNT_W'(DETECT_DELAY);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DETECT_DELAY + DATA_BITS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REP_HOLD - 1);

    typedef enum logic [2:0] {IDLE, SEEK, REPLICATE, TRANSFER, STOP, DONE} stateType;

    stateType          state;
    logic [1:0]        posSync, coilSync;
    logic              posPrev, step, abortNow, bitHit;
    logic [ADDR_W-1:0] targetPage, nextPosition;
    logic [CNT_W-1:0]  xferCount, nextCount;
    logic [HOLD_W-1:0] holdCount;

    assign step         = posSync[1] & ~posPrev;
    assign nextPosition = (current_position == POS_LAST) ? '0 : current_position + 1'b1;
    assign nextCount    = xferCount + 1'b1;
    assign bitHit       = (nextCount >= FIRST_BIT) && (nextCount <= LAST_BIT);
    assign abortNow     = access_abort && (state == SEEK || state == REPLICATE || state == TRANSFER);
    assign access_busy  = state != IDLE;
    assign access_done  = state == DONE;

    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            posSync             <= '0;
            coilSync            <= '0;
            posPrev             <= 1'b0;
            targetPage          <= '0;
            xferCount           <= '0;
            holdCount           <= '0;
            bubble_shift_enable <= 1'b1;
            replicator_enable   <= 1'b1;
            bootloop_enable     <= 1'b1;
            bit_valid           <= 1'b0;
            bit_index           <= '0;
            current_position    <= '0;
        end else begin
            posSync   <= {posSync[0], position_change};
            coilSync  <= {coilSync[0], coil_run};
            posPrev   <= posSync[1];
            bit_valid <= 1'b0;
            // position is tracked in every state so coasting steps are never lost
            if (step) current_position <= nextPosition;
            if (abortNow) begin
                state               <= STOP;
                bubble_shift_enable <= 1'b1;
                replicator_enable   <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (access_request) begin
                        targetPage          <= access_page;
                        bootloop_enable     <= ~bootloop_request;
                        bubble_shift_enable <= 1'b0;
                        state               <= SEEK;
                    end
                    SEEK: if (step && nextPosition == targetPage) begin
                        replicator_enable <= 1'b0;
                        holdCount         <= '0;
                        state             <= REPLICATE;
                    end
                    REPLICATE: begin
                        holdCount <= holdCount + 1'b1;
                        if (holdCount == HOLD_LAST) begin
                            replicator_enable <= 1'b1;
                            xferCount         <= CNT_W'(step);
                            state             <= TRANSFER;
                        end
                    end
                    TRANSFER: if (step) begin
                        xferCount <= nextCount;
                        if (bitHit) begin
                            bit_valid <= 1'b1;
                            bit_index <= nextCount - FIRST_BIT;
                        end
                        if (nextCount == LAST_BIT) begin
                            bubble_shift_enable <= 1'b1;
                            state               <= STOP;
                        end
                    end
                    STOP: if (!coilSync[1]) state <= DONE;
                    DONE: begin
                        bootloop_enable <= 1'b1;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
